// File: rtl/mvb_frame_stim_gen.sv
// MVB frame stimulus generator: after an idle gap, writes a patterned frame into the
// encoder FIFO, pulses send_frame, then waits for frame_over or a timeout.
`timescale 1ns/1ps
module mvb_frame_stim_gen #(
    parameter int                DATA_W      = 16,
    parameter int                MAX_WORDS   = 16,
    parameter int                GAP_CYC     = 600,
    parameter int                TIMEOUT_CYC = 4096,
    parameter logic [DATA_W-1:0] SEED        = 16'h7EC3
) (
    input  logic              clk_24M,
    input  logic              RESET,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [4:0]        word_count,
    input  logic              ms_sel,
    input  logic              frame_over,
    output logic              ce_6M,
    output logic              ce_3M,
    output logic              fifo_write_en,
    output logic [DATA_W-1:0] data_out,
    output logic [6:0]        frame_length,
    output logic              M_frame,
    output logic              S_frame,
    output logic              send_frame,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              timeout_err
);

    typedef enum logic [2:0] {IDLE, GAP, FILL, SEND, WAIT_DONE} state_t;

    localparam int         GAP_W  = $clog2(GAP_CYC + 1);
    localparam int         TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0] MAX_WC = 5'(MAX_WORDS);

    state_t            state, state_next;
    logic [2:0]        div;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [4:0]        words_done;
    logic [4:0]        len_lat;
    logic              ms_lat;
    logic [1:0]        mode_lat;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] pattern_seed;
    logic [4:0]        wc_clamped;
    logic              gap_done, last_write, to_expired, fill_entry, lfsr_fb;

    always_ff @(posedge clk_24M) begin
        if (!RESET) div <= 3'd0;
        else        div <= div + 3'd1;
    end

    assign ce_6M = (div[1:0] == 2'b11);
    assign ce_3M = (div == 3'b111);

    assign gap_done   = (gap_cnt == GAP_W'(GAP_CYC - 1));
    assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign last_write = (words_done == len_lat - 5'd1);
    assign fill_entry = (state != FILL) && (state_next == FILL);

    always_ff @(posedge clk_24M) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    // Once FILL starts the frame always runs to completion; enable only matters at the edges.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (enable) state_next = GAP;
            GAP: begin
                if (!enable)       state_next = IDLE;
                else if (gap_done) state_next = FILL;
            end
            FILL:      if (ce_3M && last_write) state_next = SEND;
            SEND:      state_next = WAIT_DONE;
            WAIT_DONE: if (frame_over || to_expired) state_next = enable ? GAP : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        fifo_write_en = (state == FILL) && ce_3M;
        send_frame    = (state == SEND);
        M_frame       = busy && ms_lat;
        S_frame       = busy && !ms_lat;
    end

    always_comb begin
        wc_clamped = word_count;
        if (word_count == 5'd0)        wc_clamped = 5'd1;
        else if (word_count > MAX_WC)  wc_clamped = MAX_WC;
    end

    // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
    always_comb begin
        case (mode)
            2'b10:   pattern_seed = (SEED == '0) ? DATA_W'(1) : SEED;
            2'b11:   pattern_seed = DATA_W'(1);
            default: pattern_seed = SEED;
        endcase
    end

    // Taps sit relative to the MSB, giving x^16+x^14+x^13+x^11+1 for a 16-bit word.
    assign lfsr_fb = pattern[DATA_W-1] ^ pattern[DATA_W-3] ^ pattern[DATA_W-4] ^ pattern[DATA_W-6];

    always_ff @(posedge clk_24M) begin
        if (!RESET) begin
            gap_cnt     <= '0;
            to_cnt      <= '0;
            words_done  <= 5'd0;
            len_lat     <= 5'd0;
            ms_lat      <= 1'b0;
            mode_lat    <= 2'b00;
            pattern     <= '0;
            frame_cnt   <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            gap_cnt <= (state == GAP)       ? gap_cnt + GAP_W'(1) : '0;
            to_cnt  <= (state == WAIT_DONE) ? to_cnt + TO_W'(1)   : '0;
            if (fill_entry) begin
                words_done <= 5'd0;
                len_lat    <= wc_clamped;
                ms_lat     <= ms_sel;
                mode_lat   <= mode;
                pattern    <= pattern_seed;
            end else if (fifo_write_en) begin
                words_done <= words_done + 5'd1;
                case (mode_lat)
                    2'b00:   pattern <= pattern + DATA_W'(1);
                    2'b01:   pattern <= pattern;
                    2'b10:   pattern <= {pattern[DATA_W-2:0], lfsr_fb};
                    default: pattern <= {pattern[DATA_W-2:0], pattern[DATA_W-1]};
                endcase
            end
            if (state == WAIT_DONE) begin
                if (frame_over)      frame_cnt   <= frame_cnt + 16'd1;
                else if (to_expired) timeout_err <= 1'b1;
            end
        end
    end

    assign data_out     = pattern;
    assign frame_length = {2'b00, len_lat};

endmodule

// File: tb/tb_mvb_frame_stim_gen.sv
// Randomized bench for mvb_frame_stim_gen; two instances (default seed and seed 0)
// run in lockstep against a cycle-timeline model of frames.
`timescale 1ns/1ps
module tb_mvb_frame_stim_gen;

    localparam int GAP_CYC     = 600;
    localparam int TIMEOUT_CYC = 4096;
    localparam int NUM_FRAMES  = 14;

    logic        clk_24M = 1'b0;
    logic        RESET, enable, ms_sel, frame_over;
    logic [1:0]  mode;
    logic [4:0]  word_count;

    logic        ce6Std, ce3Std, wrStd, mStd, sStd, sendStd, busyStd, terrStd;
    logic [15:0] dataStd, fcntStd;
    logic [6:0]  flenStd;
    logic        ce6Zero, ce3Zero, wrZero, mZero, sZero, sendZero, busyZero, terrZero;
    logic [15:0] dataZero, fcntZero;
    logic [6:0]  flenZero;

    int unsigned cyc;
    int          checkCount, failCount, expFrameCnt;
    logic        expTimeout;
    int unsigned gs;

    mvb_frame_stim_gen #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dutStd (
        .clk_24M(clk_24M), .RESET(RESET), .enable(enable), .mode(mode),
        .word_count(word_count), .ms_sel(ms_sel), .frame_over(frame_over),
        .ce_6M(ce6Std), .ce_3M(ce3Std), .fifo_write_en(wrStd), .data_out(dataStd),
        .frame_length(flenStd), .M_frame(mStd), .S_frame(sStd), .send_frame(sendStd),
        .busy(busyStd), .frame_cnt(fcntStd), .timeout_err(terrStd));

    mvb_frame_stim_gen #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .SEED(16'h0000)) dutZero (
        .clk_24M(clk_24M), .RESET(RESET), .enable(enable), .mode(mode),
        .word_count(word_count), .ms_sel(ms_sel), .frame_over(frame_over),
        .ce_6M(ce6Zero), .ce_3M(ce3Zero), .fifo_write_en(wrZero), .data_out(dataZero),
        .frame_length(flenZero), .M_frame(mZero), .S_frame(sZero), .send_frame(sendZero),
        .busy(busyZero), .frame_cnt(fcntZero), .timeout_err(terrZero));

    always #21 clk_24M = ~clk_24M;

    // Cycle index since the last reset edge; the divider should equal it mod 8.
    always @(posedge clk_24M) begin
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [15:0] patternWord(input logic [1:0] m, input logic [15:0] seed, input int i);
        logic [15:0] r;
        case (m)
            2'b00: return seed + 16'(i);
            2'b01: return seed;
            2'b10: begin
                r = (seed == 16'h0) ? 16'h1 : seed;
                for (int k = 0; k < i; k++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
                return r;
            end
            default: return 16'h1 << (i % 16);
        endcase
    endfunction

    function automatic int clampLen(input logic [4:0] wc);
        if (wc == 0) return 1;
        if (wc > 16) return 16;
        return int'(wc);
    endfunction

    task automatic step();
        @(negedge clk_24M);
        frame_over = 1'b0;
        checkOutput("ce_6M", ce6Std, (cyc % 4) == 3);
        checkOutput("ce_3M", ce3Std, (cyc % 8) == 7);
        checkOutput("ce_6M_z", ce6Zero, (cyc % 4) == 3);
        checkOutput("ce_3M_z", ce3Zero, (cyc % 8) == 7);
    endtask

    task automatic checkCycle(input logic expWr, input logic expSend, input logic expBusy);
        checkOutput("fifo_write_en", wrStd, expWr);
        checkOutput("send_frame", sendStd, expSend);
        checkOutput("busy", busyStd, expBusy);
        checkOutput("fifo_write_en_z", wrZero, expWr);
        checkOutput("send_frame_z", sendZero, expSend);
        checkOutput("busy_z", busyZero, expBusy);
        if (!expBusy) checkOutput("ms_idle", {mStd, sStd, mZero, sZero}, 4'b0000);
    endtask

    task automatic checkResetState();
        checkCycle(1'b0, 1'b0, 1'b0);
        checkOutput("rst_data", dataStd, 0);
        checkOutput("rst_data_z", dataZero, 0);
        checkOutput("rst_len", {flenStd, flenZero}, 0);
        checkOutput("rst_fcnt", {fcntStd, fcntZero}, 0);
        checkOutput("rst_terr", {terrStd, terrZero}, 0);
    endtask

    task automatic checkWord(input int idx, input logic [1:0] m, input logic ms, input int len);
        checkOutput("data", dataStd, patternWord(m, 16'h7EC3, idx));
        checkOutput("data_z", dataZero, patternWord(m, 16'h0000, idx));
        checkOutput("frame_length", flenStd, len);
        checkOutput("frame_length_z", flenZero, len);
        checkOutput("M_frame", {mStd, mZero}, {ms, ms});
        checkOutput("S_frame", {sStd, sZero}, {!ms, !ms});
    endtask

    // Drives the parameters for frame nf; the DUT latches them when that frame's FILL starts.
    task automatic applyStimulus(input int nf);
        case (nf)
            0: begin mode = 2'b00; word_count = 5'd16; ms_sel = 1'b1; end
            1: begin mode = 2'b10; word_count = 5'd0;  ms_sel = 1'b0; end
            2: begin mode = 2'b10; word_count = 5'd31; ms_sel = 1'b1; end
            3: begin mode = 2'b11; word_count = 5'd20; ms_sel = 1'b0; end
            4: begin mode = 2'b01; word_count = 5'd5;  ms_sel = 1'b1; end
            6: begin mode = 2'b00; word_count = 5'd10; ms_sel = 1'b0; end
            7: begin mode = 2'b10; word_count = 5'd3;  ms_sel = 1'b1; end
            default: begin
                mode       = 2'($urandom_range(0, 3));
                word_count = 5'($urandom_range(0, 31));
                ms_sel     = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic runFrame(input int f, input int unsigned gsIn, output int unsigned gsOut);
        int unsigned g, fillStart, w0, sendCyc, exitCyc, c;
        int          len, d, idx;
        logic [1:0]  m;
        logic        ms, isWr, timeoutFrame;
        g = gsIn;
        if (f == 5) begin
            repeat (5) begin checkCycle(1'b0, 1'b0, 1'b1); step(); end
            checkCycle(1'b0, 1'b0, 1'b1);
            enable = 1'b0;
            step();
            repeat (4) begin checkCycle(1'b0, 1'b0, 1'b0); step(); end
            enable = 1'b1;
            step();
            g = cyc;
        end
        m = mode; ms = ms_sel; len = clampLen(word_count);
        fillStart = g + GAP_CYC;
        w0        = fillStart + (7 - fillStart % 8);
        sendCyc   = w0 + 8 * (len - 1) + 1;
        forever begin
            c    = cyc;
            isWr = (c >= w0) && ((c - w0) % 8 == 0) && ((c - w0) / 8 < len);
            idx  = int'((c - w0) / 8);
            checkCycle(isWr, c == sendCyc, 1'b1);
            if (isWr) begin
                checkWord(idx, m, ms, len);
                if (idx == 0) applyStimulus(f + 1);
                if (f == 4 && idx == 2) enable = 1'b0;
                if (f == 6 && idx == 4) begin
                    RESET = 1'b0;
                    step();
                    checkResetState();
                    RESET = 1'b1;
                    expFrameCnt = 0;
                    expTimeout  = 1'b0;
                    step();
                    gsOut = cyc;
                    return;
                end
            end else if ($urandom_range(0, 99) == 0) begin
                frame_over = 1'b1;
            end
            if (c == sendCyc) break;
            step();
        end
        checkOutput("frame_cnt_pre", fcntStd, expFrameCnt);
        timeoutFrame = (f == 3);
        d       = (f == 0) ? 20 : $urandom_range(1, 60);
        exitCyc = timeoutFrame ? sendCyc + TIMEOUT_CYC + 1 : sendCyc + d + 1;
        step();
        while (cyc < exitCyc) begin
            checkCycle(1'b0, 1'b0, 1'b1);
            if (timeoutFrame && cyc == exitCyc - 1) checkOutput("timeout_early", terrStd, 0);
            if (!timeoutFrame && cyc == sendCyc + d) frame_over = 1'b1;
            step();
        end
        if (timeoutFrame) expTimeout = 1'b1;
        else              expFrameCnt = (expFrameCnt + 1) % 65536;
        checkOutput("frame_cnt", fcntStd, expFrameCnt);
        checkOutput("frame_cnt_z", fcntZero, expFrameCnt);
        checkOutput("timeout_err", terrStd, expTimeout);
        checkOutput("timeout_err_z", terrZero, expTimeout);
        checkCycle(1'b0, 1'b0, enable);
        if (!enable) begin
            repeat (30) begin step(); checkCycle(1'b0, 1'b0, 1'b0); end
            enable = 1'b1;
            step();
        end
        gsOut = cyc;
    endtask

    initial begin
        #(200000 * 42);
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0; failCount = 0; expFrameCnt = 0; expTimeout = 1'b0;
        RESET = 1'b0; enable = 1'b0; mode = 2'b00; word_count = 5'd0; ms_sel = 1'b0; frame_over = 1'b0;
        repeat (3) step();
        checkResetState();
        RESET = 1'b1;
        applyStimulus(0);
        repeat (5) begin step(); checkCycle(1'b0, 1'b0, 1'b0); end
        enable = 1'b1;
        step();
        gs = cyc;
        for (int f = 0; f < NUM_FRAMES; f++) runFrame(f, gs, gs);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mvb_frame_stim_gen.md
MVB_FRAME_STIM_GEN -- requirements
Module: mvb_frame_stim_gen

Interface
REQ-001 Parameter DATA_W, 16, width of each frame data word.
REQ-002 Parameter MAX_WORDS, 16, maximum words per frame, 1..31.
REQ-003 Parameter GAP_CYC, 600, clk_24M cycles of idle gap before each frame.
REQ-004 Parameter TIMEOUT_CYC, 4096, clk_24M cycles allowed for frame_over after send_frame.
REQ-005 Parameter SEED, 16'h7EC3, first data word of every frame.
REQ-006 clk_24M  in  1  block clock; all logic on its rising edge.
REQ-007 RESET  in  1  synchronous, active-low reset.
REQ-008 enable  in  1  high = generate frames continuously.
REQ-009 mode  in  2  data pattern: 00 increment, 01 constant, 10 LFSR, 11 walking-one.
REQ-010 word_count  in  5  requested words per frame.
REQ-011 ms_sel  in  1  1 = master frame, 0 = slave frame.
REQ-012 frame_over  in  1  encoder end-of-frame pulse.
REQ-013 ce_6M / ce_3M  out  1 each  single-cycle clock enables at 24M/4 and 24M/8.
REQ-014 fifo_write_en  out  1  data_out valid, write to encoder FIFO.
REQ-015 data_out  out  DATA_W  frame data word.
REQ-016 frame_length  out  7  latched word count of current frame, zero-extended.
REQ-017 M_frame / S_frame  out  1 each  frame type, held for the whole frame.
REQ-018 send_frame  out  1  one-cycle start-transmit pulse.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 frame_cnt  out  16  completed frames, wraps FFFF->0000.
REQ-021 timeout_err  out  1  sticky, set on frame_over timeout.

Function
REQ-022 3-bit free-running divider; ce_6M high when div[1:0]==3, ce_3M high when div==7.
REQ-023 FSM states IDLE, GAP, FILL, SEND, WAIT_DONE.
REQ-024 IDLE->GAP when enable=1; gap counter cleared on entry.
REQ-025 GAP: count GAP_CYC cycles, then ->FILL; enable=0 during GAP ->IDLE.
REQ-026 FILL entry latches word_count (0 -> 1, >MAX_WORDS -> MAX_WORDS) into frame_length, latches ms_sel, and reloads the pattern generator.
REQ-027 FILL: one write per ce_3M cycle; fifo_write_en high exactly that cycle, data_out valid the same cycle.
REQ-028 After the last write, go to SEND; SEND asserts send_frame for one cycle, then ->WAIT_DONE.
REQ-029 WAIT_DONE: frame_over=1 -> increment frame_cnt, ->GAP (enable=1) or IDLE (enable=0).
REQ-030 WAIT_DONE: TIMEOUT_CYC cycles without frame_over -> set timeout_err, do not increment frame_cnt, take the same exit.
REQ-031 enable falling during FILL/SEND/WAIT_DONE does not abort; the current frame completes.
REQ-032 frame_over outside WAIT_DONE is ignored.
REQ-033 Pattern word i (i = 0..n-1): incr SEED+i mod 2^DATA_W; constant SEED; LFSR SEED then Fibonacci x^16+x^14+x^13+x^11+1 shifted left, feedback into bit 0; walking-one 1<<(i mod DATA_W).
REQ-034 LFSR seed 0 is replaced by 1.
REQ-035 mode is sampled at FILL entry; changes mid-frame take effect next frame.
REQ-036 M_frame = latched ms_sel, S_frame = ~latched ms_sel while busy; both 0 in IDLE.

Reset
REQ-037 RESET=0 at a clock edge: state IDLE, div=0, all counters 0, all outputs 0, data_out 0, timeout_err cleared.
REQ-038 Reset mid-frame abandons the frame with no send_frame and no frame_cnt change.

Verification
REQ-039 enable=1, mode=00, word_count=16, frame_over 20 cycles after send_frame -> 16 writes 7EC3..7ED2 spaced 8 cycles, then send_frame, frame_cnt=1.
REQ-040 word_count=0 and word_count=31 (MAX_WORDS=16) -> frame_length 1 and 16 respectively.
REQ-041 mode=10, SEED=0, 3 words -> data 0001, 0002, 0004.
REQ-042 frame_over never returned -> timeout_err=1 after TIMEOUT_CYC cycles, frame_cnt unchanged, next frame starts after GAP_CYC.
REQ-043 enable dropped mid-FILL -> frame completes, busy falls after frame_over, no further frames.
REQ-044 RESET pulsed during word 5 -> all outputs 0 next cycle, no send_frame, div restarts at 0.
